// File: rtl/muon_frame_builder_pkg.sv
// Shared types for the muon frame builder feeding the bitonic sorter.
package muon_frame_builder_pkg;

  localparam int unsigned PT_W        = 9;
  localparam int unsigned ETA_W       = 9;
  localparam int unsigned PHI_W       = 10;
  localparam int unsigned QUAL_W      = 4;
  localparam int unsigned FRAME_WIDTH = 8;

  // One muon candidate; the builder forwards it without looking inside.
  typedef struct packed {
    logic [PT_W-1:0]   pt;
    logic [ETA_W-1:0]  eta;
    logic [PHI_W-1:0]  phi;
    logic [QUAL_W-1:0] quality;
  } muon_t;

  // Filler for unused frame slots.
  localparam muon_t MUON_NULL = '0;

  typedef enum logic [0:0] {
    FILL    = 1'b0,
    DISCARD = 1'b1
  } fill_state_t;

endpackage

// File: rtl/muon_frame_builder.sv
// Packs serially arriving muons of one bunch crossing into a null-padded,
// double-buffered frame for the sorter input.
module muon_frame_builder
  import muon_frame_builder_pkg::*;
#(
  parameter int unsigned WIDTH  = FRAME_WIDTH,
  parameter int unsigned DROP_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  muon_t                   s_muon,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output muon_t                   m_frame [WIDTH],
  output logic [$clog2(WIDTH):0]  m_count,
  output logic                    m_trunc,
  output logic [DROP_W-1:0]       drop_cnt
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  fill_state_t      state;
  logic [IDX_W-1:0] cnt;
  logic             pend;
  logic [CNT_W-1:0] cnt_frame;
  logic             trunc_frame;
  muon_t            fill_buf [WIDTH];

  logic             accept;
  logic             fill_acc;
  logic             at_end;
  logic             close;
  logic             close_trunc;
  logic             out_free;
  logic             direct;
  logic             xfer_pend;
  logic             load;
  muon_t            src_frame [WIDTH];
  logic [CNT_W-1:0] src_len;
  logic             src_trunc;

  // Fill stalls only while a closed frame is parked in the buffer; discard never stalls.
  always_comb begin
    s_ready = 1'b0;
    if (!rst) s_ready = (state == DISCARD) || !pend;
  end

  // Close/transfer decode; a closing beat bypasses the buffer when the output is free.
  always_comb begin
    accept      = s_valid && s_ready;
    fill_acc    = accept && (state == FILL);
    at_end      = (cnt == IDX_W'(WIDTH - 1));
    close       = fill_acc && (s_last || at_end);
    close_trunc = fill_acc && !s_last && at_end;
    out_free    = !m_valid || m_ready;
    direct      = close && out_free;
    xfer_pend   = pend && out_free;
    load        = direct || xfer_pend;
    src_len     = direct ? ({1'b0, cnt} + CNT_W'(1)) : cnt_frame;
    src_trunc   = direct ? close_trunc : trunc_frame;
    src_frame   = fill_buf;
    if (direct) src_frame[cnt] = s_muon;
  end

  // Fill FSM, pending-frame flag, drop counter and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      cnt         <= '0;
      pend        <= 1'b0;
      cnt_frame   <= '0;
      trunc_frame <= 1'b0;
      m_valid     <= 1'b0;
      m_count     <= '0;
      m_trunc     <= 1'b0;
      drop_cnt    <= '0;
      for (int i = 0; i < int'(WIDTH); i++) m_frame[i] <= MUON_NULL;
    end else begin
      if (fill_acc) begin
        fill_buf[cnt] <= s_muon;
        cnt           <= close ? '0 : cnt + IDX_W'(1);
      end

      if (close && !out_free) begin
        pend        <= 1'b1;
        cnt_frame   <= {1'b0, cnt} + CNT_W'(1);
        trunc_frame <= close_trunc;
      end else if (xfer_pend) begin
        pend <= 1'b0;
      end

      if (close_trunc) state <= DISCARD;

      if (accept && (state == DISCARD)) begin
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
        if (s_last) state <= FILL;
      end

      if (load) begin
        for (int i = 0; i < int'(WIDTH); i++)
          m_frame[i] <= (CNT_W'(i) < src_len) ? src_frame[i] : MUON_NULL;
        m_count <= src_len;
        m_trunc <= src_trunc;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muon_frame_builder.sv
// Self-checking bench for muon_frame_builder with a per-bunch-crossing reference model.
module tb_muon_frame_builder;
  import muon_frame_builder_pkg::*;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned DROP_W   = 16;
  localparam int unsigned DROP_MAX = (1 << DROP_W) - 1;
  localparam int unsigned CNT_W    = $clog2(WIDTH) + 1;
  localparam int          LIMIT    = 500;

  typedef struct packed {
    muon_t [WIDTH-1:0] slots;
    logic [CNT_W-1:0]  count;
    logic              trunc;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  muon_t             s_muon;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  muon_t             m_frame [WIDTH];
  logic [CNT_W-1:0]  m_count;
  logic              m_trunc;
  logic [DROP_W-1:0] drop_cnt;

  int          asserts;
  int          fails;
  bit          rand_ready;
  muon_t       part_q[$];
  int          part_n;
  exp_t        exp_q[$];
  int unsigned drop_exp;
  int          delivered;

  bit               hold_prev;
  muon_t            prev_frame [WIDTH];
  logic [CNT_W-1:0] prev_count;
  logic             prev_trunc;

  muon_frame_builder #(.WIDTH(WIDTH), .DROP_W(DROP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_muon   (s_muon),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_frame  (m_frame),
    .m_count  (m_count),
    .m_trunc  (m_trunc),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a bunch crossing yields one frame of its first WIDTH muons; the frame
  // leaves as soon as its WIDTH-th muon arrives without last, and the rest are dropped.
  function automatic void model_accept(input muon_t mu, input logic last);
    exp_t e;
    part_n++;
    if (part_n <= int'(WIDTH)) part_q.push_back(mu);
    else if (drop_exp < DROP_MAX) drop_exp++;
    if ((last && part_n <= int'(WIDTH)) || (!last && part_n == int'(WIDTH))) begin
      e.slots = '0;
      for (int i = 0; i < part_q.size(); i++) e.slots[i] = part_q[i];
      e.count = CNT_W'(part_q.size());
      e.trunc = !last;
      exp_q.push_back(e);
      part_q.delete();
    end
    if (last) begin
      part_q.delete();
      part_n = 0;
    end
  endfunction

  // Output monitor: frame contents on each handshake, hold stability and drop count.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 64'(m_valid), 64'(1));
        chk("hold_count", 64'(m_count), 64'(prev_count));
        chk("hold_trunc", 64'(m_trunc), 64'(prev_trunc));
        for (int i = 0; i < int'(WIDTH); i++)
          chk("hold_slot", 64'(m_frame[i]), 64'(prev_frame[i]));
      end
      if (m_valid && m_ready) begin
        chk("frame_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("frame_count", 64'(m_count), 64'(e.count));
          chk("frame_trunc", 64'(m_trunc), 64'(e.trunc));
          for (int i = 0; i < int'(WIDTH); i++)
            chk("frame_slot", 64'(m_frame[i]), 64'(e.slots[i]));
        end
        delivered++;
      end
      chk("drop_cnt", 64'(drop_cnt), 64'(drop_exp));
      hold_prev  = m_valid && !m_ready;
      prev_frame = m_frame;
      prev_count = m_count;
      prev_trunc = m_trunc;
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input muon_t mu, input logic last, output int waits);
    logic rdy;
    s_valid = 1'b1;
    s_muon  = mu;
    s_last  = last;
    waits   = 0;
    rdy     = 1'b0;
    while (!rdy && waits <= LIMIT) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      if (rdy) model_accept(mu, last);
      else waits++;
      #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end
    chk("accept_timeout", 64'(rdy), 64'(1));
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < LIMIT) begin
      idle(1);
      c++;
    end
    idle(2);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset_values();
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_count", 64'(m_count), 64'(0));
    chk("rst_m_trunc", 64'(m_trunc), 64'(0));
    chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    for (int i = 0; i < int'(WIDTH); i++)
      chk("rst_slot_null", 64'(m_frame[i]), 64'(MUON_NULL));
  endtask

  initial begin
    int    w;
    int    n;
    int    base;
    muon_t mu;

    asserts    = 0;
    fails      = 0;
    rand_ready = 1'b0;
    part_n     = 0;
    drop_exp   = 0;
    delivered  = 0;
    hold_prev  = 1'b0;
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_muon     = MUON_NULL;
    s_last     = 1'b0;
    m_ready    = 1'b1;

    // Reset state
    idle(3);
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Three muons A,B,C: frame one cycle after C
    send(muon_t'(32'hA0A0_0001), 1'b0, w);
    send(muon_t'(32'hB0B0_0002), 1'b0, w);
    send(muon_t'(32'hC0C0_0003), 1'b1, w);
    @(negedge clk);
    chk("latency_m_valid", 64'(m_valid), 64'(1));
    chk("abc_count", 64'(m_count), 64'(3));
    drain();

    // Ten muons in one crossing: first eight framed, two dropped, next frame clean
    for (int k = 0; k < 10; k++) begin
      send(muon_t'(32'h1000 + k), 1'(k == 9), w);
      chk("overflow_no_stall", 64'(w), 64'(0));
    end
    chk("drop_after_overflow", 64'(drop_cnt), 64'(2));
    send(muon_t'(32'h2222_0001), 1'b0, w);
    send(muon_t'(32'h2222_0002), 1'b1, w);
    drain();

    // Output stalled: first frame held, second pending, input blocked
    m_ready = 1'b0;
    idle(2);
    send(muon_t'(32'h3333_0001), 1'b0, w);
    send(muon_t'(32'h3333_0002), 1'b0, w);
    send(muon_t'(32'h3333_0003), 1'b1, w);
    send(muon_t'(32'h4444_0001), 1'b0, w);
    send(muon_t'(32'h4444_0002), 1'b1, w);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("stall_s_ready", 64'(s_ready), 64'(0));
      chk("stall_m_count", 64'(m_count), 64'(3));
      idle(1);
    end
    m_ready = 1'b1;
    drain();
    chk("stall_both_out", 64'(exp_q.size()), 64'(0));

    // Back-to-back single-muon frames at full rate
    base = delivered;
    for (int k = 0; k < 6; k++) begin
      send(muon_t'(32'h5500 + k), 1'b1, w);
      chk("b2b_no_stall", 64'(w), 64'(0));
    end
    @(negedge clk);
    chk("b2b_m_valid", 64'(m_valid), 64'(1));
    drain();
    chk("b2b_delivered", 64'(delivered - base), 64'(6));

    // Randomized crossings with random backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 150; f++) begin
      n = int'($urandom_range(1, 11));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        mu = muon_t'($urandom);
        send(mu, 1'(k == n - 1), w);
      end
    end
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    drain();

    // Reset in the middle of a frame
    for (int k = 0; k < 4; k++) send(muon_t'(32'h6600 + k), 1'b0, w);
    rst = 1'b1;
    @(posedge clk);
    part_q.delete();
    part_n   = 0;
    exp_q.delete();
    drop_exp = 0;
    #1;
    check_reset_values();
    rst = 1'b0;
    idle(1);
    send(muon_t'(32'h7777_0001), 1'b0, w);
    send(muon_t'(32'h7777_0002), 1'b1, w);
    @(negedge clk);
    chk("post_rst_count", 64'(m_count), 64'(2));
    drain();

    // Drop counter saturation
    for (int k = 0; k < int'(WIDTH) + int'(DROP_MAX) + 1; k++)
      send(muon_t'(k), 1'(k == int'(WIDTH) + int'(DROP_MAX)), w);
    @(negedge clk);
    chk("drop_saturated", 64'(drop_cnt), 64'(DROP_MAX));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
